floating_mul: RTL and testbench
===============================

FLOATING_MUL -- requirements
Module: floating_mul

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 32-bit IEEE-754 binary32.
REQ-002 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  a/b carry an operand pair this cycle.
REQ-006 a  input  32  binary32 multiplicand.
REQ-007 b  input  32  binary32 multiplier.
REQ-008 out_valid  output  1  y holds a result this cycle.
REQ-009 y  output  32  binary32 product, registered.

Function
REQ-010 The block SHALL be a 2-stage pipeline: latency 2 clocks from an in_valid sample to out_valid; throughput 1 operation per clock; no stall or backpressure.
REQ-011 Stage 1 SHALL unpack a and b, compute sign = sa XOR sb and exponent sum ea+eb-127 (signed, at least 10 bits), form 24x24 mantissa product with hidden 1, classify special cases, and register the results with in_valid.
REQ-012 Stage 2 SHALL normalise, round, handle overflow/underflow, assemble y and register it with out_valid.
REQ-013 Normalisation: if product bit 47 is 1, take mantissa bits 46:24 and increment the exponent; otherwise take bits 45:23.
REQ-014 Rounding SHALL be round-to-nearest-even using the guard bit and a sticky OR of all lower bits.
REQ-015 A rounding carry out of the mantissa SHALL set mantissa to 0 and increment the exponent.
REQ-016 Subnormal inputs (exp=0, frac!=0) SHALL be treated as signed zero (DAZ).
REQ-017 A final exponent >= 255 SHALL produce signed infinity ({sign,8'hFF,23'h0}).
REQ-018 A final exponent <= 0 SHALL produce signed zero ({sign,31'h0}); no subnormal outputs are generated.
REQ-019 Special-case priority, highest first:
- Either input NaN -> y = 32'h7FC00000.
- Infinity times zero -> y = 32'h7FC00000.
- Either input infinity -> signed infinity.
- Either input zero -> signed zero.
REQ-020 When out_valid is 0, y SHALL hold its last value.
REQ-021 Each pipeline stage SHALL load only when its incoming valid is 1.
REQ-022 Valid bits SHALL advance every clock.
REQ-023 Back-to-back operands on consecutive cycles SHALL each emerge, in order, exactly 2 cycles later.

Reset
REQ-024 While rst_n = 0, all pipeline registers, out_valid and y SHALL clear to 0 asynchronously.
REQ-025 Operations in flight when reset asserts SHALL be discarded, and no out_valid SHALL appear for them.
REQ-026 After rst_n deasserts, the first out_valid SHALL occur 2 clocks after the first sampled in_valid.

Verification
REQ-027 The bench SHALL cover basic products, 2 cycles after each in_valid:
- a=3FC00000, b=40000000 -> y=40400000.
- a=40400000, b=3F800000 -> y=40400000.
- a=3F800000, b=3F800000 -> y=3F800000.
REQ-028 The bench SHALL cover zero, infinity, NaN and sign cases:
- a=00000000, b=3F800000 -> y=00000000.
- a=7F800000, b=3F800000 -> y=7F800000.
- a=7F800000, b=00000000 -> y=7FC00000.
- a=BF800000, b=40000000 -> y=C0000000.
REQ-029 The bench SHALL cover overflow, underflow and rounding:
- a=7F000000, b=40000000 -> y=7F800000.
- a=00800000, b=00800000 -> y=00000000.
- a=3F800001, b=3F800001 -> y=3F800002 (RNE).
REQ-030 The bench SHALL drive in_valid high for 5 consecutive cycles with distinct operands and check 5 consecutive out_valid pulses with in-order results.
REQ-031 The bench SHALL assert rst_n low mid-stream and check y=0 and out_valid=0 immediately, with no stale results afterwards.

Source files
------------

// File: rtl/floating_mul.sv
// Two-stage binary32 multiplier: stage 1 unpacks, classifies and multiplies mantissas;
// stage 2 normalises, rounds to nearest even and packs. Subnormal inputs flush to zero.
module floating_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] y
);

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_t;

    logic [7:0]         ea, eb;
    logic [22:0]        fa, fb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    cls_t               cls_d;
    logic signed [9:0]  exp_sum_d;
    logic [47:0]        man_a, man_b, prod_d;

    logic               s1_valid;
    logic               s1_sign;
    cls_t               s1_cls;
    logic signed [9:0]  s1_exp;
    logic [47:0]        s1_prod;

    logic [22:0]        mant;
    logic               guard, sticky, round_up;
    logic [23:0]        mant_rnd;
    logic [22:0]        frac_f;
    logic signed [9:0]  exp_n, exp_f;
    logic [31:0]        y_d;

    always_comb begin
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        // exponent 0 covers both true zero and subnormals (flushed to zero)
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (fa == 23'h0);
        b_inf  = (eb == 8'hFF) && (fb == 23'h0);
        a_nan  = (ea == 8'hFF) && (fa != 23'h0);
        b_nan  = (eb == 8'hFF) && (fb != 23'h0);

        if (a_nan || b_nan)
            cls_d = CLS_NAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            cls_d = CLS_NAN;
        else if (a_inf || b_inf)
            cls_d = CLS_INF;
        else if (a_zero || b_zero)
            cls_d = CLS_ZERO;
        else
            cls_d = CLS_NORM;

        exp_sum_d = signed'({2'b00, ea}) + signed'({2'b00, eb}) - 10'sd127;
        man_a     = {24'h0, 1'b1, fa};
        man_b     = {24'h0, 1'b1, fb};
        prod_d    = man_a * man_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_NORM;
            s1_exp   <= '0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= a[31] ^ b[31];
                s1_cls  <= cls_d;
                s1_exp  <= exp_sum_d;
                s1_prod <= prod_d;
            end
        end
    end

    always_comb begin
        if (s1_prod[47]) begin
            mant   = s1_prod[46:24];
            guard  = s1_prod[23];
            sticky = |s1_prod[22:0];
            exp_n  = s1_exp + 10'sd1;
        end else begin
            mant   = s1_prod[45:23];
            guard  = s1_prod[22];
            sticky = |s1_prod[21:0];
            exp_n  = s1_exp;
        end

        round_up = guard && (sticky || mant[0]);
        mant_rnd = {1'b0, mant} + {23'h0, round_up};
        // rounding past all-ones rolls the significand over to the next binade
        if (mant_rnd[23]) begin
            frac_f = '0;
            exp_f  = exp_n + 10'sd1;
        end else begin
            frac_f = mant_rnd[22:0];
            exp_f  = exp_n;
        end

        case (s1_cls)
            CLS_NAN:  y_d = 32'h7FC0_0000;
            CLS_INF:  y_d = {s1_sign, 8'hFF, 23'h0};
            CLS_ZERO: y_d = {s1_sign, 31'h0};
            default: begin
                if (exp_f >= 10'sd255)
                    y_d = {s1_sign, 8'hFF, 23'h0};
                else if (exp_f <= 10'sd0)
                    y_d = {s1_sign, 31'h0};
                else
                    y_d = {s1_sign, exp_f[7:0], frac_f};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid)
                y <= y_d;
        end
    end

endmodule

// File: tb/tb_floating_mul.sv
// Self-checking bench for floating_mul: directed vectors plus a randomized scoreboard
// driven by a real-arithmetic reference of binary32 multiply (DAZ/FTZ, RNE).
module tb_floating_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] y;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    floating_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y)
    );

    // Reference: exact product of significands in double precision, then rounded to 23 bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] z);
        int          ex, ez, de, e;
        logic        s, x_zero, z_zero, x_inf, z_inf, x_nan, z_nan, up;
        real         mx, mz, p;
        logic [63:0] bits;
        logic [22:0] keep;
        logic [28:0] rem;
        logic [23:0] sum;
        ex     = int'(x[30:23]);
        ez     = int'(z[30:23]);
        s      = x[31] ^ z[31];
        x_zero = (ex == 0);
        z_zero = (ez == 0);
        x_inf  = (ex == 255) && (x[22:0] == 23'h0);
        z_inf  = (ez == 255) && (z[22:0] == 23'h0);
        x_nan  = (ex == 255) && (x[22:0] != 23'h0);
        z_nan  = (ez == 255) && (z[22:0] != 23'h0);
        if (x_nan || z_nan) return 32'h7FC0_0000;
        if ((x_inf && z_zero) || (z_inf && x_zero)) return 32'h7FC0_0000;
        if (x_inf || z_inf) return {s, 8'hFF, 23'h0};
        if (x_zero || z_zero) return {s, 31'h0};
        mx   = 1.0 + real'(x[22:0]) / 8388608.0;
        mz   = 1.0 + real'(z[22:0]) / 8388608.0;
        p    = mx * mz;
        bits = $realtobits(p);
        de   = int'(bits[62:52]) - 1023;
        keep = bits[51:29];
        rem  = bits[28:0];
        up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
        sum  = {1'b0, keep} + {23'h0, up};
        if (sum[23]) begin
            de   = de + 1;
            keep = '0;
        end else begin
            keep = sum[22:0];
        end
        e = ex + ez - 127 + de;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), keep};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned k;
        logic [31:0] r;
        k = $urandom_range(0, 15);
        r = $urandom;
        case (k)
            0:       r[30:23] = 8'h00;
            1:       r[30:23] = 8'hFF;
            2:       begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
            3:       r[30:0] = 31'h0;
            4, 5:    r[30:23] = 8'($urandom_range(1, 254));
            default: r[30:23] = 8'($urandom_range(96, 160));
        endcase
        return r;
    endfunction

    task automatic run_single(input logic [31:0] xa, input logic [31:0] xb,
                              output logic v_early, output logic v_out, output logic [31:0] y_out);
        @(negedge clk);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk);
        #1 v_early = out_valid;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
        v_out = out_valid;
        y_out = y;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests++;
        if (y !== 32'h0) begin
            fails++;
            $display("FAIL reset_y: got %h expected 00000000", y);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] va[3] = '{32'h3FC0_0000, 32'h4040_0000, 32'h3F80_0000};
        logic [31:0] vb[3] = '{32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
        logic [31:0] ve[3] = '{32'h4040_0000, 32'h4040_0000, 32'h3F80_0000};
        logic        v0, v1;
        logic [31:0] got;
        for (int i = 0; i < 3; i++) begin
            run_single(va[i], vb[i], v0, v1, got);
            tests++;
            if (v0 !== 1'b0) begin
                fails++;
                $display("FAIL basic_latency_early[%0d]: out_valid %b expected 0", i, v0);
            end
            tests++;
            if (v1 !== 1'b1) begin
                fails++;
                $display("FAIL basic_valid[%0d]: out_valid %b expected 1", i, v1);
            end
            tests++;
            if (got !== ve[i]) begin
                fails++;
                $display("FAIL basic_y[%0d]: %h*%h got %h expected %h", i, va[i], vb[i], got, ve[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || y !== 32'h3F80_0000) begin
            fails++;
            $display("FAIL hold_y: out_valid %b y %h expected 0 / 3f800000", out_valid, y);
        end
    endtask

    task automatic test_special();
        logic [31:0] va[4] = '{32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 32'hBF80_0000};
        logic [31:0] vb[4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000};
        logic [31:0] ve[4] = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'hC000_0000};
        logic        v0, v1;
        logic [31:0] got;
        for (int i = 0; i < 4; i++) begin
            run_single(va[i], vb[i], v0, v1, got);
            tests++;
            if (v1 !== 1'b1 || got !== ve[i]) begin
                fails++;
                $display("FAIL special[%0d]: %h*%h got valid %b y %h expected 1 / %h",
                         i, va[i], vb[i], v1, got, ve[i]);
            end
        end
    endtask

    task automatic test_ovf_round();
        logic [31:0] va[3] = '{32'h7F00_0000, 32'h0080_0000, 32'h3F80_0001};
        logic [31:0] vb[3] = '{32'h4000_0000, 32'h0080_0000, 32'h3F80_0001};
        logic [31:0] ve[3] = '{32'h7F80_0000, 32'h0000_0000, 32'h3F80_0002};
        logic        v0, v1;
        logic [31:0] got;
        for (int i = 0; i < 3; i++) begin
            run_single(va[i], vb[i], v0, v1, got);
            tests++;
            if (v1 !== 1'b1 || got !== ve[i]) begin
                fails++;
                $display("FAIL ovf_round[%0d]: %h*%h got valid %b y %h expected 1 / %h",
                         i, va[i], vb[i], v1, got, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea[5], eb[5], ex[5];
        logic        want;
        for (int i = 0; i < 5; i++) begin
            ea[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            eb[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            ex[i] = ref_mul(ea[i], eb[i]);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 5) begin
                in_valid = 1'b1;
                a = ea[c];
                b = eb[c];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            want = (c >= 1) && (c <= 5);
            tests++;
            if (out_valid !== want) begin
                fails++;
                $display("FAIL b2b_valid[cycle %0d]: got %b expected %b", c, out_valid, want);
            end
            if (want) begin
                tests++;
                if (y !== ex[c-1]) begin
                    fails++;
                    $display("FAIL b2b_y[%0d]: got %h expected %h", c - 1, y, ex[c-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q[$];
        int          due_q[$];
        logic        want;
        logic [31:0] e;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c < 390 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                a = rand_fp();
                b = rand_fp();
                exp_q.push_back(ref_mul(a, b));
                due_q.push_back(c + 1);
            end else begin
                in_valid = 1'b0;
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            want = (due_q.size() > 0) && (due_q[0] == c);
            tests++;
            if (out_valid !== want) begin
                fails++;
                $display("FAIL rand_valid[cycle %0d]: got %b expected %b", c, out_valid, want);
            end
            if (want) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                tests++;
                if (y !== e) begin
                    fails++;
                    $display("FAIL rand_y[cycle %0d]: got %h expected %h", c, y, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_drain: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic        v0, v1;
        logic [31:0] got;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 32'h4040_0000 + 32'(c);
            b = 32'h4000_0000;
            @(posedge clk);
            #1;
        end
        tests++;
        if (out_valid !== 1'b1 || y !== ref_mul(32'h4040_0000, 32'h4000_0000)) begin
            fails++;
            $display("FAIL pre_reset: valid %b y %h expected 1 / %h",
                     out_valid, y, ref_mul(32'h4040_0000, 32'h4000_0000));
        end
        @(negedge clk);
        a = 32'h4080_0000;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || y !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: valid %b y %h expected 0 / 00000000", out_valid, y);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL stale_after_reset[%0d]: out_valid %b expected 0", c, out_valid);
            end
        end
        run_single(32'h3FC0_0000, 32'h4000_0000, v0, v1, got);
        tests++;
        if (v0 !== 1'b0 || v1 !== 1'b1 || got !== 32'h4040_0000) begin
            fails++;
            $display("FAIL first_after_reset: early %b valid %b y %h expected 0 / 1 / 40400000",
                     v0, v1, got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_ovf_round();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
